// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues single-outstanding requests to an instruction memory, buffers up to
// two returned words in order, and presents the oldest one to decode.
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   imem_req / imem_addr      request strobe and word address (combinational)
//   imem_ack / imem_rdata     response strobe and instruction word
//   stall                     decode not ready; head entry is held
//   PCSrc / PCTarget          taken branch for the presented instruction
//   instr_valid, Instr, PC_D, PCPlus4_D   head entry presented to decode
//   OP6_0, funct3_2_0, funct7_5           decoded fields of Instr
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic [6:0]  OP6_0,
  output logic [2:0]  funct3_2_0,
  output logic        funct7_5
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned DEPTH = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_req_pc;
  entry_t           r_buf [DEPTH];

  logic             w_valid;
  logic             w_consume;
  logic             w_redirect;
  logic             w_push;
  logic [CNT_W-1:0] w_wr_slot;
  logic [XLEN-1:0]  w_target;
  entry_t           w_new;

  // Handshake with decode: a consume pops the head; PCSrc only counts on a consume.
  assign w_valid    = (r_count != '0);
  assign w_consume  = w_valid && !stall;
  assign w_redirect = w_consume && PCSrc;
  assign w_target   = PCTarget & ~32'd3;
  assign w_new      = '{pc: r_req_pc, instr: imem_rdata};
  // Tail slot after an optional same-cycle pop.
  assign w_wr_slot  = w_consume ? (r_count - CNT_W'(1)) : r_count;

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. An ack always retires the outstanding request, so a
  // redirect coinciding with an ack drops the data (w_push) and returns to
  // IDLE rather than waiting in DISCARD for a response that will never come.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (imem_req) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (imem_ack)        w_state_nxt = S_IDLE;
        else if (w_redirect) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: request only with a free slot; never in a redirect cycle or in reset.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = r_fetch_pc;
    w_push    = 1'b0;
    case (r_state)
      S_IDLE:  imem_req = (r_count < CNT_W'(DEPTH)) && !w_redirect && !RST;
      S_BUSY:  w_push   = imem_ack && !w_redirect;
      default: begin
        imem_req = 1'b0;
        w_push   = 1'b0;
      end
    endcase
  end

  // Fetch PC, request PC, occupancy and the two-entry in-order buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count    <= '0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (imem_req) begin
        r_req_pc <= r_fetch_pc;
      end
      if (w_redirect) begin
        r_count    <= '0;
        r_fetch_pc <= w_target;
      end else begin
        if (imem_req) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_consume);
        // Shift on pop; a push to the same slot is written last and wins.
        if (w_consume) begin
          r_buf[0] <= r_buf[1];
        end
        if (w_push) begin
          r_buf[w_wr_slot[0]] <= w_new;
        end
      end
    end
  end

  // Head presentation; an empty buffer shows a NOP at PC 0.
  assign instr_valid = w_valid;
  assign Instr       = w_valid ? r_buf[0].instr : NOP_INSTR;
  assign PC_D        = w_valid ? r_buf[0].pc : '0;
  assign PCPlus4_D   = PC_D + 32'd4;
  assign OP6_0       = Instr[6:0];
  assign funct3_2_0  = Instr[14:12];
  assign funct7_5    = Instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'h0;
  logic        instr_valid;
  logic [31:0] Instr, PC_D, PCPlus4_D;
  logic [6:0]  OP6_0;
  logic [2:0]  funct3_2_0;
  logic        funct7_5;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_valid;
  logic [31:0] wr_instr, wr_pc, wr_pc4;
  logic [6:0]  wr_op;
  logic [2:0]  wr_f3;
  logic        wr_f7;

  always #5 CLK = ~CLK;

  fetch_unit u_dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(instr_valid), .Instr(Instr), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .OP6_0(OP6_0), .funct3_2_0(funct3_2_0), .funct7_5(funct7_5)
  );

  // Second instance only to observe PC wrap from the top of the address space.
  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .CLK(CLK), .RST(RST),
    .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .instr_valid(wr_valid), .Instr(wr_instr), .PC_D(wr_pc), .PCPlus4_D(wr_pc4),
    .OP6_0(wr_op), .funct3_2_0(wr_f3), .funct7_5(wr_f7)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: queue of presented entries plus one outstanding request.
  ent_t        mq[$];
  bit          m_out  = 1'b0;
  bit          m_keep = 1'b0;
  logic [31:0] m_opc  = 32'h0;
  logic [31:0] m_fpc  = 32'h0;

  // Memory responder: fixed latency in cycles from request to ack.
  int          lat   = 1;
  int          mcnt  = 0;
  logic [31:0] maddr = 32'h0;
  bit          spur  = 1'b0;

  logic [31:0] req_log[$];
  logic [31:0] req_cyc[$];
  logic [31:0] wrap_log[$];
  logic [31:0] con_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h4000_0033;
    return {a[23:0], 8'h93};
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    m_out  = 1'b0;
    m_keep = 1'b0;
    m_fpc  = 32'h0;
    mcnt   = 0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance.
  task automatic step(input logic st, input logic br, input logic [31:0] tgt);
    logic        e_valid, e_req, cons, redir;
    logic [31:0] e_instr, e_pc;
    ent_t        ne;
    stall      = st;
    PCSrc      = br;
    PCTarget   = tgt;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (spur) begin
      imem_ack = 1'b1;
      spur     = 1'b0;
    end else if (mcnt == 1) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(maddr);
      mcnt       = 0;
    end
    #1;
    e_valid = !RST && (mq.size() != 0);
    cons    = e_valid && !st;
    redir   = cons && br;
    e_req   = !RST && !m_out && (mq.size() < 2) && !redir;
    e_instr = NOP;
    e_pc    = 32'h0;
    if (e_valid) begin
      e_instr = mq[0].instr;
      e_pc    = mq[0].pc;
    end
    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, m_fpc);
    chk("Instr", Instr, e_instr);
    chk("PC_D", PC_D, e_pc);
    chk("PCPlus4_D", PCPlus4_D, e_pc + 32'd4);
    chk("OP6_0", 32'(OP6_0), 32'(e_instr[6:0]));
    chk("funct3_2_0", 32'(funct3_2_0), 32'(e_instr[14:12]));
    chk("funct7_5", 32'(funct7_5), 32'(e_instr[30]));

    if (imem_req) begin
      req_log.push_back(imem_addr);
      req_cyc.push_back(32'(cyc));
      maddr = imem_addr;
      mcnt  = lat;
    end else if (mcnt > 1) begin
      mcnt--;
    end
    if (wr_req) wrap_log.push_back(wr_addr);
    if (instr_valid && !st) con_log.push_back(PC_D);

    if (RST) begin
      model_reset();
    end else begin
      if (cons) void'(mq.pop_front());
      if (imem_ack && m_out) begin
        if (m_keep && !redir) begin
          ne.pc    = m_opc;
          ne.instr = imem_rdata;
          mq.push_back(ne);
        end
        m_out = 1'b0;
      end
      if (redir) begin
        mq.delete();
        m_fpc = {tgt[31:2], 2'b00};
        if (m_out) m_keep = 1'b0;
      end
      if (e_req) begin
        m_out  = 1'b1;
        m_keep = 1'b1;
        m_opc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    wrap_log.delete();
    con_log.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    RST = 1'b0;
    clear_logs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit did;
    bit done;
    @(negedge CLK);

    // Back-to-back fetch after reset with single-cycle memory.
    lat = 1;
    do_reset();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    chk("A req0", qat(req_log, 0), 32'h0);
    chk("A req1", qat(req_log, 1), 32'h4);
    chk("A req2", qat(req_log, 2), 32'h8);
    chk("A first req cycle", qat(req_cyc, 0), 32'(cyc - 8));
    chk("A req gap1", qat(req_cyc, 1) - qat(req_cyc, 0), 32'd2);
    chk("A req gap2", qat(req_cyc, 2) - qat(req_cyc, 1), 32'd2);
    chk("A consume0", qat(con_log, 0), 32'h0);
    chk("A consume1", qat(con_log, 1), 32'h4);
    chk("A wrap req0", qat(wrap_log, 0), 32'hFFFF_FFFC);
    chk("A wrap req1", qat(wrap_log, 1), 32'h0);

    // Stall held: exactly two entries fill, then drain in order.
    do_reset();
    repeat (10) step(1'b1, 1'b0, 32'h0);
    chk("B req count", 32'(req_log.size()), 32'd2);
    chk("B valid held", 32'(instr_valid), 32'd1);
    chk("B head held", PC_D, 32'h0);
    con_log.delete();
    repeat (4) step(1'b0, 1'b0, 32'h0);
    chk("B drain0", qat(con_log, 0), 32'h0);
    chk("B drain1", qat(con_log, 1), 32'h4);

    // Redirect from PC 0x8 with a request outstanding; late ack is dropped.
    do_reset();
    lat  = 3;
    did  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (mq.size() != 0 && mq[0].pc == 32'h8) begin
        if (!did) begin
          step(1'b1, 1'b0, 32'h0);
          did = 1'b1;
        end else begin
          chk("C outstanding at redirect", 32'(m_out), 32'd1);
          step(1'b0, 1'b1, 32'h0000_0103);
          done = 1'b1;
        end
      end else begin
        step(1'b0, 1'b0, 32'h0);
      end
    end
    chk("C redirect reached", 32'(done), 32'd1);
    chk("C flushed", 32'(instr_valid), 32'd0);
    clear_logs();
    for (int i = 0; i < 12 && !instr_valid; i++) step(1'b1, 1'b0, 32'h0);
    chk("C next addr", qat(req_log, 0), 32'h100);
    chk("C target PC_D", PC_D, 32'h100);
    chk("C target Instr", Instr, 32'h4000_0033);
    chk("C OP6_0", 32'(OP6_0), 32'h33);
    chk("C funct3", 32'(funct3_2_0), 32'h0);
    chk("C funct7_5", 32'(funct7_5), 32'h1);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    lat = 3;
    repeat (5) step(1'b1, 1'b0, 32'h0);
    chk("D valid before reset", 32'(instr_valid), 32'd1);
    chk("D outstanding before reset", 32'(m_out), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("D async imem_req", 32'(imem_req), 32'd0);
    chk("D async instr_valid", 32'(instr_valid), 32'd0);
    chk("D async Instr", Instr, NOP);
    chk("D async PC_D", PC_D, 32'h0);
    model_reset();
    @(negedge CLK);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    RST = 1'b0;
    clear_logs();
    lat  = 1;
    spur = 1'b1;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    chk("D first req", qat(req_log, 0), 32'h0);
    chk("D first consume", qat(con_log, 0), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
